vga_timing_gen: RTL and testbench

Parametrised, single-clock VGA timing generator that replaces the separate horizontal/vertical counter-comparator pair. It derives the pixel rate internally from the system clock, sequences both axes from one clock domain, and emits registered sync, display-enable, pixel coordinates and line/frame start strobes. It sits between the system clock and the pixel/RGB logic of the VGA driver.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_axis_counter.sv | 67 ++++++
 rtl/vga_timing_gen.sv | 167 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator.
// Holds the per-axis segment struct, the 640x480@60 segment constants,
// the default counter width and a helper that sums an axis into its total.
package vga_pkg;

    // One axis of a video timing: lengths of the four segments in the order
    // they occur (sync, back porch, active, front porch).
    typedef struct packed {
        int sync;
        int back;
        int active;
        int front;
    } vga_axis_t;

    localparam int VGA_CW = 10;

    localparam vga_axis_t VGA_640X480_H = '{sync: 96, back: 48, active: 640, front: 16};
    localparam vga_axis_t VGA_640X480_V = '{sync: 2,  back: 33, active: 480, front: 10};

    function automatic int axis_total(input vga_axis_t a);
        return a.sync + a.back + a.active + a.front;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One axis (horizontal or vertical) of the VGA timing generator.
// Counts 0..TOTAL-1, advancing on adv and wrapping after the last position,
// and decodes the current count into segment flags.
//
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous active-low reset
//   adv     in   advance the counter by one position this clock
//   count   out  current position, 0..TOTAL-1
//   wrap    out  count is at the last position (next adv returns to 0)
//   sync_n  out  low while count is inside the sync segment
//   active  out  high while count is inside the active segment
//   pos     out  offset into the active segment, 0 outside it
module vga_axis_counter #(
    parameter int CW     = 10,
    parameter int SYNC   = 96,
    parameter int BACK   = 48,
    parameter int ACTIVE = 640,
    parameter int FRONT  = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          adv,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          sync_n,
    output logic          active,
    output logic [CW-1:0] pos
);

    localparam int TOTAL = SYNC + BACK + ACTIVE + FRONT;

    // Segment boundaries as CW-bit constants so every compare is same-width.
    localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_END = CW'(SYNC);
    localparam logic [CW-1:0] ACT_LO   = CW'(SYNC + BACK);
    localparam logic [CW-1:0] ACT_HI   = CW'(SYNC + BACK + ACTIVE);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        // NOTE: the hold value is assigned first so every path through this
        // block drives count_d; a missing default would infer a latch.
        count_d = count_q;
        if (adv) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign wrap   = (count_q == LAST);
    assign sync_n = (count_q >= SYNC_END);
    assign active = (count_q >= ACT_LO) && (count_q < ACT_HI);
    // Never wraps: only evaluated when count_q is at or above ACT_LO.
    assign pos    = active ? (count_q - ACT_LO) : '0;

endmodule

// File: rtl/vga_timing_gen.sv
// Single-clock VGA timing generator.
// A divider derives the pixel tick from the system clock; two axis counters
// track (hcount, vcount). On each tick the decode of the current position is
// registered onto the outputs while the counters advance, so all outputs lag
// the counters by exactly one tick and change together.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   enable       in   low freezes divider, counters and outputs
//   hsync        out  horizontal sync, HSYNC_POL during the pulse
//   vsync        out  vertical sync, VSYNC_POL during the pulse
//   de           out  display enable, both axes in their active segment
//   x            out  active pixel column, 0 when de=0
//   y            out  active line, 0 when de=0
//   line_start   out  one-clock pulse when the pixel at hcount=0 is shown
//   frame_start  out  one-clock pulse when the pixel at (0,0) is shown
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int CW        = VGA_CW,
    parameter int H_SYNC    = VGA_640X480_H.sync,
    parameter int H_BACK    = VGA_640X480_H.back,
    parameter int H_ACTIVE  = VGA_640X480_H.active,
    parameter int H_FRONT   = VGA_640X480_H.front,
    parameter int V_SYNC    = VGA_640X480_V.sync,
    parameter int V_BACK    = VGA_640X480_V.back,
    parameter int V_ACTIVE  = VGA_640X480_V.active,
    parameter int V_FRONT   = VGA_640X480_V.front,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam vga_axis_t H_AXIS = '{sync: H_SYNC, back: H_BACK, active: H_ACTIVE, front: H_FRONT};
    localparam vga_axis_t V_AXIS = '{sync: V_SYNC, back: V_BACK, active: V_ACTIVE, front: V_FRONT};
    localparam int H_TOTAL = axis_total(H_AXIS);
    localparam int V_TOTAL = axis_total(V_AXIS);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_total
        $error("vga_timing_gen: axis total does not fit in CW bits");
    end
    if (H_SYNC < 1 || H_BACK < 1 || H_ACTIVE < 1 || H_FRONT < 1 ||
        V_SYNC < 1 || V_BACK < 1 || V_ACTIVE < 1 || V_FRONT < 1) begin : g_bad_segment
        $error("vga_timing_gen: every segment length must be >= 1");
    end

    // Divider: width is at least one bit so CLK_DIV=1 still elaborates; in
    // that case div_q stays 0 and tick simply follows enable.
    localparam int              DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          tick;

    assign tick = enable && (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q;
        if (enable) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
    end

    logic [CW-1:0] h_count, h_pos, v_count, v_pos;
    logic          h_wrap, h_sync_n, h_active;
    logic          v_wrap_unused, v_sync_n, v_active;

    vga_axis_counter #(
        .CW(CW), .SYNC(H_SYNC), .BACK(H_BACK), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT)
    ) u_h_axis (
        .clk    (clk),
        .reset  (reset),
        .adv    (tick),
        .count  (h_count),
        .wrap   (h_wrap),
        .sync_n (h_sync_n),
        .active (h_active),
        .pos    (h_pos)
    );

    vga_axis_counter #(
        .CW(CW), .SYNC(V_SYNC), .BACK(V_BACK), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT)
    ) u_v_axis (
        .clk    (clk),
        .reset  (reset),
        .adv    (tick && h_wrap),
        .count  (v_count),
        .wrap   (v_wrap_unused),
        .sync_n (v_sync_n),
        .active (v_active),
        .pos    (v_pos)
    );

    // Output register stage.
    logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic          both_active;

    assign both_active = h_active && v_active;

    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        x_d           = x_q;
        y_d           = y_q;
        // Strobes only survive the tick edge that produced them.
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (tick) begin
            hsync_d       = h_sync_n ? ~HSYNC_POL : HSYNC_POL;
            vsync_d       = v_sync_n ? ~VSYNC_POL : VSYNC_POL;
            de_d          = both_active;
            x_d           = both_active ? h_pos : '0;
            y_d           = both_active ? v_pos : '0;
            line_start_d  = (h_count == '0);
            frame_start_d = (h_count == '0) && (v_count == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q         <= '0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one instance at the 640x480 defaults and one
// small variant (CLK_DIV=1, H 2/2/4/2, V 1/1/2/1, HSYNC_POL=1). Each instance
// is compared every clock against a model that derives the outputs from the
// number of enabled clock edges since reset, plus literal spot checks.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit hs, vs, de;
        int x, y;
        bit ls, fs;
    } exp_t;

    // Expected outputs after e enabled edges since reset; lt says whether the
    // most recent edge was an enabled tick edge.
    function automatic exp_t model(input int e, input bit lt, input int div,
                                   input int hs_w, input int hb, input int ha, input int hf,
                                   input int vs_w, input int vb, input int va, input int vf,
                                   input bit hp, input bit vp);
        exp_t m;
        int p, idx, ht, vt, hc, vc;
        bit hact, vact;
        p = e / div;
        m = '{hs: ~hp, vs: ~vp, de: 1'b0, x: 0, y: 0, ls: 1'b0, fs: 1'b0};
        if (p == 0) return m;
        idx  = p - 1;
        ht   = hs_w + hb + ha + hf;
        vt   = vs_w + vb + va + vf;
        hc   = idx % ht;
        vc   = (idx / ht) % vt;
        hact = (hc >= hs_w + hb) && (hc < hs_w + hb + ha);
        vact = (vc >= vs_w + vb) && (vc < vs_w + vb + va);
        m.hs = (hc < hs_w) ? hp : ~hp;
        m.vs = (vc < vs_w) ? vp : ~vp;
        m.de = hact && vact;
        m.x  = m.de ? hc - hs_w - hb : 0;
        m.y  = m.de ? vc - vs_w - vb : 0;
        m.ls = lt && (hc == 0);
        m.fs = m.ls && (vc == 0);
        return m;
    endfunction

    // ---------------- default instance ----------------
    logic       rst_d, en_d;
    logic       hs_d, vs_d, de_d, ls_d, fs_d;
    logic [9:0] x_d, y_d;

    vga_timing_gen u_def (
        .clk         (clk),
        .reset       (rst_d),
        .enable      (en_d),
        .hsync       (hs_d),
        .vsync       (vs_d),
        .de          (de_d),
        .x           (x_d),
        .y           (y_d),
        .line_start  (ls_d),
        .frame_start (fs_d)
    );

    // ---------------- variant instance ----------------
    logic       rst_v, en_v;
    logic       hs_v, vs_v, de_v, ls_v, fs_v;
    logic [9:0] x_v, y_v;

    vga_timing_gen #(
        .CLK_DIV(1), .CW(10),
        .H_SYNC(2), .H_BACK(2), .H_ACTIVE(4), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_ACTIVE(2), .V_FRONT(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
    ) u_var (
        .clk         (clk),
        .reset       (rst_v),
        .enable      (en_v),
        .hsync       (hs_v),
        .vsync       (vs_v),
        .de          (de_v),
        .x           (x_v),
        .y           (y_v),
        .line_start  (ls_v),
        .frame_start (fs_v)
    );

    // Model state: enabled-edge count and "last edge was a tick".
    int e_def, e_var;
    bit lt_def, lt_var;

    always @(posedge clk or negedge rst_d) begin
        if (!rst_d) begin
            e_def  <= 0;
            lt_def <= 1'b0;
        end else if (en_d) begin
            e_def  <= e_def + 1;
            lt_def <= ((e_def + 1) % 2) == 0;
        end else begin
            lt_def <= 1'b0;
        end
    end

    always @(posedge clk or negedge rst_v) begin
        if (!rst_v) begin
            e_var  <= 0;
            lt_var <= 1'b0;
        end else if (en_v) begin
            e_var  <= e_var + 1;
            lt_var <= 1'b1;
        end else begin
            lt_var <= 1'b0;
        end
    end

    task automatic cmp(input string tag, input exp_t m, input logic hs, input logic vs,
                       input logic de, input logic [9:0] x, input logic [9:0] y,
                       input logic ls, input logic fs);
        check({tag, "_hsync"}, hs, m.hs);
        check({tag, "_vsync"}, vs, m.vs);
        check({tag, "_de"}, de, m.de);
        check({tag, "_x"}, x, m.x);
        check({tag, "_y"}, y, m.y);
        check({tag, "_line_start"}, ls, m.ls);
        check({tag, "_frame_start"}, fs, m.fs);
    endtask

    // Every-cycle comparison, 1 time unit after the falling edge.
    always begin
        @(negedge clk);
        #1;
        cmp("def_model", model(e_def, lt_def, 2, 96, 48, 640, 16, 2, 33, 480, 10, 1'b0, 1'b0),
            hs_d, vs_d, de_d, x_d, y_d, ls_d, fs_d);
        cmp("var_model", model(e_var, lt_var, 1, 2, 2, 4, 2, 1, 1, 2, 1, 1'b1, 1'b0),
            hs_v, vs_v, de_v, x_v, y_v, ls_v, fs_v);
    end

    task automatic seq_default();
        int hlow = 0;
        rst_d = 1'b0;
        en_d  = 1'b1;
        repeat (3) @(negedge clk);
        #3 rst_d = 1'b1;
        for (int k = 1; k <= 57570; k++) begin
            @(negedge clk);
            #2;
            if (k >= 2 && k <= 1601 && hs_d == 1'b0) hlow++;
            case (k)
                1: begin
                    check("def_k1_hsync", hs_d, 1);
                    check("def_k1_frame_start", fs_d, 0);
                end
                2: begin
                    check("def_k2_hsync", hs_d, 0);
                    check("def_k2_vsync", vs_d, 0);
                    check("def_k2_frame_start", fs_d, 1);
                    check("def_k2_line_start", ls_d, 1);
                end
                3: begin
                    check("def_k3_frame_start", fs_d, 0);
                    check("def_k3_line_start", ls_d, 0);
                end
                1602: begin
                    check("def_line2_line_start", ls_d, 1);
                    check("def_line2_frame_start", fs_d, 0);
                end
                1603: check("def_line2_ls_drop", ls_d, 0);
                3201: check("def_vsync_last_low", vs_d, 0);
                3202: check("def_vsync_release", vs_d, 1);
                56290: begin
                    check("def_win_de", de_d, 1);
                    check("def_win_x0", x_d, 0);
                    check("def_win_y0", y_d, 0);
                end
                56291: check("def_win_x0_hold", x_d, 0);
                56292: check("def_win_x1", x_d, 1);
                57568: begin
                    check("def_x639", x_d, 639);
                    check("def_x639_de", de_d, 1);
                end
                57569: check("def_x639_hold", x_d, 639);
                57570: begin
                    check("def_after_active_de", de_d, 0);
                    check("def_after_active_x", x_d, 0);
                end
                default: ;
            endcase
        end
        check("def_hsync_low_clocks", hlow, 192);
    endtask

    task automatic seq_variant();
        logic       snap_hs;
        logic [9:0] snap_x;
        rst_v = 1'b0;
        en_v  = 1'b1;
        repeat (3) @(negedge clk);
        #3 rst_v = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            #2;
            if (k >= 25 && k <= 28) begin
                check("var_x_seq", x_v, k - 25);
                check("var_x_seq_de", de_v, 1);
                check("var_x_seq_y", y_v, 0);
            end
            case (k)
                1: begin
                    check("var_k1_hsync", hs_v, 1);
                    check("var_k1_vsync", vs_v, 0);
                    check("var_k1_frame_start", fs_v, 1);
                    check("var_k1_line_start", ls_v, 1);
                end
                2: begin
                    check("var_k2_hsync", hs_v, 1);
                    check("var_k2_frame_start", fs_v, 0);
                end
                3:  check("var_k3_hsync", hs_v, 0);
                11: begin
                    check("var_line_period", ls_v, 1);
                    check("var_line_fs", fs_v, 0);
                    check("var_vsync_release", vs_v, 1);
                end
                29: check("var_after_active_de", de_v, 0);
                51: check("var_frame_period", fs_v, 1);
                52: check("var_frame_fs_drop", fs_v, 0);
                default: ;
            endcase
        end

        // Random enable gaps, checked by the every-cycle model.
        repeat (1500) begin
            @(negedge clk);
            en_v = ($urandom_range(0, 3) != 0);
        end

        // 37-clock stall: outputs frozen, strobes low.
        @(negedge clk);
        en_v = 1'b1;
        repeat (($urandom_range(0, 7)) + 3) @(negedge clk);
        en_v = 1'b0;
        #2;
        snap_hs = hs_v;
        snap_x  = x_v;
        for (int k = 0; k < 37; k++) begin
            @(negedge clk);
            #2;
            check("var_stall_hsync", hs_v, snap_hs);
            check("var_stall_x", x_v, snap_x);
            check("var_stall_line_start", ls_v, 0);
            check("var_stall_frame_start", fs_v, 0);
        end
        en_v = 1'b1;
        repeat (23) @(negedge clk);

        // Asynchronous reset between clock edges.
        #3 rst_v = 1'b0;
        #1;
        check("var_async_hsync", hs_v, 0);
        check("var_async_vsync", vs_v, 1);
        check("var_async_de", de_v, 0);
        check("var_async_x", x_v, 0);
        check("var_async_strobes", {ls_v, fs_v}, 0);
        repeat (2) @(negedge clk);
        #3 rst_v = 1'b1;
        @(negedge clk);
        #2;
        check("var_restart_frame_start", fs_v, 1);
        check("var_restart_line_start", ls_v, 1);
        check("var_restart_hsync", hs_v, 1);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            seq_default();
            seq_variant();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
